// File: rtl/shared_counter_sched.sv
// Round-robin scheduler that lends one shared up-counter to NUM_REQ requesters.
// Each grant counts out the requester's latched interval, then pulses done for one cycle.
module shared_counter_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_len,
  input  logic                     pause,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_R = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     len_q;
  logic [IDX_W-1:0]     win_q;
  logic [IDX_W-1:0]     last_q;

  logic [IDX_W-1:0]     win_d;
  logic                 found_d;
  logic [IDX_W-1:0]     cand_d;

  // Round-robin pick: first set request after last_q, wrapping; first hit wins.
  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    cand_d  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_d = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!found_d && req[cand_d]) begin
        found_d = 1'b1;
        win_d   = cand_d;
      end else begin
        found_d = found_d;
      end
    end
  end

  // Scheduler FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
      win_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= '0;
          if (found_d) begin
            state_q <= ST_RUN;
            gnt_q   <= ONE_R << win_d;
            len_q   <= req_len[win_d*CNT_W +: CNT_W];
            win_q   <= win_d;
            busy_q  <= 1'b1;
            count_q <= '0;
          end else begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
          end
        end
        ST_RUN: begin
          if (!req[win_q]) begin
            // Requester let go early: release the counter without a done pulse.
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            last_q  <= win_q;
          end else if (pause) begin
            count_q <= count_q;
          end else if (count_q == (len_q - ONE_C)) begin
            state_q <= ST_DONE;
            done_q  <= gnt_q;
          end else begin
            count_q <= count_q + ONE_C;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
          last_q  <= win_q;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_shared_counter_sched.sv
// Scoreboard bench for shared_counter_sched: stimulus queues expected grant/done
// events, a monitor consumes them; per-cycle timing is checked alongside.
module tb_shared_counter_sched;

  localparam int NR = 4;
  localparam int CW = 8;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*CW-1:0] req_len;
  logic             pause;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic             busy;
  logic [CW-1:0]    count;

  typedef struct {
    bit         is_done;
    logic [3:0] vec;
    logic [7:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  shared_counter_sched #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_len (req_len),
    .pause   (pause),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input bit d, input logic [3:0] v, input logic [7:0] c);
    ev_t e;
    e.is_done = d;
    e.vec     = v;
    e.cnt     = c;
    exp_q.push_back(e);
  endtask

  task automatic set_len(input int i, input logic [7:0] v);
    req_len[i*CW +: CW] = v;
  endtask

  // Monitor: every grant rise and every done pulse must match the next queued event.
  initial begin
    logic [3:0] prev;
    ev_t e;
    prev = 4'b0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 4'b0000;
      end else begin
        if (gnt != 4'b0000 && prev == 4'b0000) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_gnt", int'(gnt), 0);
          end else begin
            e = exp_q.pop_front();
            chk("ev_kind_gnt", 0, int'(e.is_done));
            chk("sb_gnt_vec", int'(gnt), int'(e.vec));
          end
        end
        if (done != 4'b0000) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", int'(done), 0);
          end else begin
            e = exp_q.pop_front();
            chk("ev_kind_done", 1, int'(e.is_done));
            chk("sb_done_vec", int'(done), int'(e.vec));
            chk("sb_done_cnt", int'(count), int'(e.cnt));
          end
          chk("done_has_gnt", int'(gnt), int'(done));
        end
        prev = gnt;
      end
    end
  end

  initial begin
    int t1_cnt[4];
    int t3_cnt[6];
    int k;
    int ph;
    t1_cnt = '{0, 1, 2, 2};
    t3_cnt = '{0, 1, 1, 1, 2, 3};

    rst = 1'b1; req = 4'b0000; req_len = '0; pause = 1'b0;
    step(); step();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);

    // Single request, length 3
    rst = 1'b0;
    set_len(0, 8'd3); req = 4'b0001;
    push_ev(1'b0, 4'b0001, 8'd0);
    push_ev(1'b1, 4'b0001, 8'd2);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t1_count", int'(count), t1_cnt[c-1]);
      chk("t1_gnt", int'(gnt), 1);
      chk("t1_busy", int'(busy), 1);
      chk("t1_done", int'(done), (c == 4) ? 1 : 0);
    end
    req = 4'b0000;
    step();
    chk("t1_busy_end", int'(busy), 0);
    chk("t1_gnt_end", int'(gnt), 0);
    chk("t1_count_end", int'(count), 0);

    // Round robin, all lengths 1, fresh reset so requester 0 wins first
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_len(i, 8'd1);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      push_ev(1'b0, 4'(1 << (g % 4)), 8'd0);
      push_ev(1'b1, 4'(1 << (g % 4)), 8'd0);
    end
    for (int c = 1; c <= 14; c++) begin
      step();
      k  = (c - 1) / 3;
      ph = (c - 1) % 3;
      chk("rr_gnt", int'(gnt), (ph == 2) ? 0 : (1 << (k % 4)));
      chk("rr_done", int'(done), (ph == 1) ? (1 << (k % 4)) : 0);
    end
    req = 4'b0000;
    step();

    // Pause two cycles while count is 1 (requester 1, length 4)
    set_len(1, 8'd4); req = 4'b0010;
    push_ev(1'b0, 4'b0010, 8'd0);
    push_ev(1'b1, 4'b0010, 8'd3);
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("pause_count", int'(count), t3_cnt[c-1]);
      chk("pause_no_done", int'(done), 0);
      if (c == 2) pause = 1'b1;
      if (c == 4) pause = 1'b0;
    end
    step();
    chk("pause_done", int'(done), 2);
    chk("pause_done_cnt", int'(count), 3);
    req = 4'b0000;
    step();

    // Zero length on requester 2: 256 ticks with natural wrap
    set_len(2, 8'd0); req = 4'b0100;
    push_ev(1'b0, 4'b0100, 8'd0);
    push_ev(1'b1, 4'b0100, 8'hFF);
    for (int c = 1; c <= 256; c++) begin
      step();
      chk("wrap_count", int'(count), c - 1);
    end
    step();
    chk("wrap_done", int'(done), 4);
    chk("wrap_done_cnt", int'(count), 255);
    req = 4'b0000;
    step();

    // Length 1 on requester 3: done in cycle 2
    set_len(3, 8'd1); req = 4'b1000;
    push_ev(1'b0, 4'b1000, 8'd0);
    push_ev(1'b1, 4'b1000, 8'd0);
    step();
    chk("len1_gnt", int'(gnt), 8);
    chk("len1_nodone", int'(done), 0);
    step();
    chk("len1_done", int'(done), 8);
    req = 4'b0000;
    step();

    // Abort: requester 0 drops at count 4, requester 2 is next
    set_len(0, 8'd10); set_len(2, 8'd2); req = 4'b0101;
    push_ev(1'b0, 4'b0001, 8'd0);
    push_ev(1'b0, 4'b0100, 8'd0);
    push_ev(1'b1, 4'b0100, 8'd1);
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("abort_count", int'(count), c - 1);
    end
    req = 4'b0100;
    step();
    chk("abort_gnt", int'(gnt), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count0", int'(count), 0);
    chk("abort_nodone", int'(done), 0);
    step();
    chk("abort_next_gnt", int'(gnt), 4);
    set_len(2, 8'd50);
    step();
    chk("abort_next_cnt", int'(count), 1);
    step();
    chk("abort_next_done", int'(done), 4);
    req = 4'b0000;
    step();

    // Reset while requester 2 is mid-run at count 5
    set_len(2, 8'd10); req = 4'b0100;
    push_ev(1'b0, 4'b0100, 8'd0);
    for (int c = 1; c <= 6; c++) step();
    chk("mid_count", int'(count), 5);
    rst = 1'b1; req = 4'b0101; set_len(0, 8'd2);
    step();
    chk("mid_rst_gnt", int'(gnt), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(count), 0);
    rst = 1'b0;
    push_ev(1'b0, 4'b0001, 8'd0);
    push_ev(1'b1, 4'b0001, 8'd1);
    step();
    chk("post_rst_gnt", int'(gnt), 1);
    step();
    step();
    chk("post_rst_done", int'(done), 1);
    req = 4'b0000;
    step(); step(); step();

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_counter_sched.md
Name: shared_counter_sched

Overview:
- Scheduler that time-shares one CNT_W-bit up-counter among NUM_REQ requesters.
- Each requester asks for an interval of N counter ticks. A round-robin arbiter grants the counter to one requester at a time.
- An FSM runs the count and returns a one-cycle done pulse to the granted requester.
- Sits between client blocks needing timed windows and the shared count datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 8, counter and length width in bits.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester request level; must stay high until done, or the run aborts.
- req_len  input  NUM_REQ*CNT_W  packed interval lengths; slice i = req_len[i*CNT_W +: CNT_W].
- pause  input  1  freezes the counter while high (RUN state only).
- gnt  output  NUM_REQ  one-hot grant, registered.
- done  output  NUM_REQ  one-hot one-cycle completion pulse, registered.
- busy  output  1  high while the counter is owned (RUN or DONE).
- count  output  CNT_W  live shared counter value.

Behaviour:
- Reset: clk and rst are one clock with synchronous active-high reset; all state changes on posedge clk. On rst high at a clock edge:
  - state=IDLE; gnt=0, done=0, busy=0, count=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-RUN aborts with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise select the winner by round-robin: scan from (last_grant+1) mod NUM_REQ upward, wrapping.
  - Next edge: gnt=onehot(winner), len_lat=req_len slice of winner, count=0, busy=1, state=RUN.
  - req_len is sampled only on this edge; later changes are ignored.
- RUN, evaluated in this priority order:
  - If req[winner]==0 (abort): next edge goes to IDLE with gnt=0, busy=0, count=0, no done; last_grant=winner.
  - Else if pause=1: count holds and the state stays RUN.
  - Else if count==len_lat-1 (mod 2^CNT_W): next edge goes to DONE, done=onehot(winner), count=len_lat-1 is held.
  - Else: count=count+1.
- DONE:
  - Lasts exactly one cycle; done is high only in this cycle and gnt is still asserted.
  - pause and req are ignored.
  - Next edge: IDLE, gnt=0, done=0, busy=0, count=0, last_grant=winner.
- Length rules:
  - len_lat=0 means 2^CNT_W ticks; count wraps naturally and the terminal value is all-ones.
  - len_lat=1 means terminal at count=0, so RUN lasts 1 cycle.
- Latency, no pause: req rises in cycle 0 (IDLE) -> gnt in cycle 1 (count=0) -> count=L-1 in cycle L -> done in cycle L+1 -> gnt low in cycle L+2. The next grant is visible at the earliest in cycle L+3.
- Each pause cycle in RUN adds exactly one cycle to this sequence.
- Simultaneous requests are resolved only in IDLE. Requests arriving during RUN/DONE wait; they are never lost while held high.
- gnt and done are always one-hot or zero; done is never asserted without the matching gnt bit.

Test Plan:
- Single request: req=0001, len0=3, no pause -> gnt=0001 in cycles 1..4; count 0,1,2 in cycles 1..3 then held at 2; done=0001 in cycle 4 only; busy low in cycle 5.
- Round robin: req=1111 held, all len=1 -> grant order 0,1,2,3,0; each gnt lasts 2 cycles (RUN+DONE) followed by 1 IDLE cycle.
- Pause: len=4, pause high for 2 cycles while count=1 -> count sequence 0,1,1,1,2,3; done arrives 2 cycles later than without pause.
- Wrap / zero length: len=0 -> count runs 0..255 over 256 RUN cycles, done on the cycle after count=0xFF, count never exceeds 0xFF; len=1 -> done in cycle 2.
- Abort: len=10, req[winner] dropped at count=4 -> next cycle gnt=0, busy=0, count=0, no done; the next waiting requester is granted per round-robin.
- Reset mid-run: rst high for 1 cycle at count=5 -> next edge all outputs 0; after release, requester 0 wins the first arbitration even if requester 2 was mid-run.
